status_io_frontend: RTL and testbench

- Parametrised board-I/O front end between the system controller and the FPGA pins.
- Registers N status channels onto pins and drives pulse-stretched copies onto LEDs so that single-cycle events are visible.
- Holds the classifier result with a pending/overrun handshake, generates the heartbeat, and synchronises and debounces one push-button input.

---
 rtl/status_io_frontend.sv | 172 +++++++++++++++++
 tb/tb_status_io_frontend.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/status_io_frontend.sv
// status_io_frontend: board-I/O front end between the system controller and
// the FPGA pins. Registers status levels onto header pins and pulse-stretched
// copies onto LEDs, latches the classifier result with a pending/overrun
// handshake, generates a heartbeat, and synchronises + debounces a push-button.
//
// Handshake semantics (result path): result_valid is a one-cycle strobe that
// always wins; result_clear is a one-cycle strobe from the consumer. A valid
// arriving while a result is still pending (and not cleared in that same
// cycle) sets the sticky overrun flag, which only reset clears.
module status_io_frontend #(
    parameter int NUM_STATUS      = 3,
    parameter int RESULT_WIDTH    = 4,
    parameter int LED_HOLD        = 5000000,
    parameter int HB_HALF         = 50000000,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_STATUS-1:0]   status_in,
    output logic [NUM_STATUS-1:0]   status_pin,
    output logic [NUM_STATUS-1:0]   status_led,
    input  logic [RESULT_WIDTH-1:0] result_in,
    input  logic                    result_valid,
    input  logic                    result_clear,
    output logic [RESULT_WIDTH-1:0] result_out,
    output logic                    result_pending,
    output logic                    result_overrun,
    input  logic                    btn_raw,
    output logic                    btn_level,
    output logic                    btn_pulse,
    output logic                    heartbeat
);

    // Counter widths are sized to hold the terminal value itself.
    localparam int HOLD_W = $clog2(LED_HOLD + 1);
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HB_W   = $clog2(HB_HALF + 1);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(LED_HOLD);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HB_W-1:0]   HB_LAST   = HB_W'(HB_HALF - 1);

    // ------------------------------------------------------------------
    // Status pins and stretched LEDs
    // ------------------------------------------------------------------
    logic [NUM_STATUS-1:0]             r_status_pin;
    logic [NUM_STATUS-1:0]             r_status_prev;
    logic [NUM_STATUS-1:0]             r_status_led;
    logic [NUM_STATUS-1:0][HOLD_W-1:0] r_hold_cnt;
    logic [NUM_STATUS-1:0]             w_status_rise;

    // A rising edge is judged on the registered pin against its previous value.
    assign w_status_rise = r_status_pin & ~r_status_prev;

    // Register status, reload hold counters on rising edges, drive stretched LEDs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status_pin  <= '0;
            r_status_prev <= '0;
            r_status_led  <= '0;
            r_hold_cnt    <= '0;
        end else begin
            r_status_pin  <= status_in;
            r_status_prev <= r_status_pin;
            for (int i = 0; i < NUM_STATUS; i++) begin
                if (w_status_rise[i]) begin
                    r_hold_cnt[i] <= HOLD_LOAD;
                end else if (r_hold_cnt[i] != '0) begin
                    r_hold_cnt[i] <= r_hold_cnt[i] - 1'b1;
                end
                r_status_led[i] <= r_status_pin[i] | (r_hold_cnt[i] != '0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Result latch with pending / sticky overrun
    // ------------------------------------------------------------------
    logic [RESULT_WIDTH-1:0] r_result_out;
    logic                    r_result_pending;
    logic                    r_result_overrun;

    // Valid beats clear; a same-cycle clear counts as consuming the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result_out     <= '0;
            r_result_pending <= 1'b0;
            r_result_overrun <= 1'b0;
        end else if (result_valid) begin
            r_result_out     <= result_in;
            r_result_pending <= 1'b1;
            if (r_result_pending && !result_clear) begin
                r_result_overrun <= 1'b1;
            end
        end else if (result_clear) begin
            r_result_pending <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Button synchroniser and debouncer
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic [DEB_W-1:0]       r_deb_cnt;
    logic                   r_btn_level;
    logic                   r_btn_pulse;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Shift the asynchronous button through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn_raw};
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb_cnt   <= '0;
            r_btn_level <= 1'b0;
            r_btn_pulse <= 1'b0;
        end else begin
            r_btn_pulse <= 1'b0;
            if (w_sync != r_btn_level) begin
                if (r_deb_cnt == DEB_LAST) begin
                    r_btn_level <= ~r_btn_level;
                    r_deb_cnt   <= '0;
                    // Pulse only on the 0->1 acceptance, coincident with the new level.
                    r_btn_pulse <= ~r_btn_level;
                end else begin
                    r_deb_cnt <= r_deb_cnt + 1'b1;
                end
            end else begin
                r_deb_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Heartbeat
    // ------------------------------------------------------------------
    logic [HB_W-1:0] r_hb_cnt;
    logic            r_heartbeat;

    // Count 0..HB_HALF-1 and toggle the heartbeat on every wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hb_cnt    <= '0;
            r_heartbeat <= 1'b0;
        end else if (r_hb_cnt == HB_LAST) begin
            r_hb_cnt    <= '0;
            r_heartbeat <= ~r_heartbeat;
        end else begin
            r_hb_cnt <= r_hb_cnt + 1'b1;
        end
    end

    assign status_pin     = r_status_pin;
    assign status_led     = r_status_led;
    assign result_out     = r_result_out;
    assign result_pending = r_result_pending;
    assign result_overrun = r_result_overrun;
    assign btn_level      = r_btn_level;
    assign btn_pulse      = r_btn_pulse;
    assign heartbeat      = r_heartbeat;

endmodule

// File: tb/tb_status_io_frontend.sv
// Bench for status_io_frontend with small parameters. A behavioural model
// derived from edge counts and timing rules is compared to the DUT after
// every clock edge; directed tests add literal expectations.
module tb_status_io_frontend;

    localparam int NS   = 3;
    localparam int RW   = 4;
    localparam int HOLD = 8;
    localparam int HB   = 5;
    localparam int SS   = 2;
    localparam int DEB  = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NS-1:0] status_in = '0;
    logic [NS-1:0] status_pin, status_led;
    logic [RW-1:0] result_in = '0;
    logic          result_valid = 1'b0, result_clear = 1'b0;
    logic [RW-1:0] result_out;
    logic          result_pending, result_overrun;
    logic          btn_raw = 1'b0;
    logic          btn_level, btn_pulse, heartbeat;

    status_io_frontend #(
        .NUM_STATUS(NS), .RESULT_WIDTH(RW), .LED_HOLD(HOLD),
        .HB_HALF(HB), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .status_in(status_in), .status_pin(status_pin), .status_led(status_led),
        .result_in(result_in), .result_valid(result_valid), .result_clear(result_clear),
        .result_out(result_out), .result_pending(result_pending), .result_overrun(result_overrun),
        .btn_raw(btn_raw), .btn_level(btn_level), .btn_pulse(btn_pulse),
        .heartbeat(heartbeat)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int            m_n;          // clock edges since reset release
    int            m_rise[NS];   // edge index of last pin rise per channel
    logic [NS-1:0] m_pin, m_led;
    logic [RW-1:0] m_out;
    logic          m_pend, m_ovr;
    logic          m_sync, m_level, m_pulse, m_hb;
    int            m_run;        // consecutive edges the sync value disagreed with level
    logic          raw_q[$];     // button samples in flight through the synchroniser

    task automatic model_reset();
        m_n = 0;
        for (int i = 0; i < NS; i++) m_rise[i] = -1000;
        m_pin = '0; m_led = '0;
        m_out = '0; m_pend = 1'b0; m_ovr = 1'b0;
        m_sync = 1'b0; m_level = 1'b0; m_pulse = 1'b0; m_hb = 1'b0;
        m_run = 0;
        raw_q.delete();
        for (int i = 0; i < SS - 1; i++) raw_q.push_back(1'b0);
    endtask

    task automatic model_step();
        logic [NS-1:0] new_led;
        logic          prev_sync;
        int            age;
        m_n++;
        // LED is lit after edges 1..HOLD+1 following a pin rise, or while pin was high.
        for (int i = 0; i < NS; i++) begin
            age = m_n - m_rise[i];
            new_led[i] = m_pin[i] | (age >= 1 && age <= HOLD + 1);
        end
        for (int i = 0; i < NS; i++) begin
            if (status_in[i] && !m_pin[i]) m_rise[i] = m_n;
        end
        m_led = new_led;
        m_pin = status_in;
        // Result handshake rules.
        if (result_valid) begin
            if (m_pend && !result_clear) m_ovr = 1'b1;
            m_out  = result_in;
            m_pend = 1'b1;
        end else if (result_clear) begin
            m_pend = 1'b0;
        end
        // Button: SS-1 edge delay to sync, then DEB consecutive disagreements.
        prev_sync = m_sync;
        raw_q.push_back(btn_raw);
        m_sync = raw_q.pop_front();
        m_pulse = 1'b0;
        if (prev_sync != m_level) begin
            m_run++;
            if (m_run == DEB) begin
                m_level = ~m_level;
                m_run   = 0;
                m_pulse = m_level;
            end
        end else begin
            m_run = 0;
        end
        // Heartbeat: level is the parity of completed half-periods.
        m_hb = ((m_n / HB) % 2) == 1;
    endtask

    // ---------------- per-cycle compare ----------------
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else        model_step();
            #1;
            chk("status_pin",     32'(status_pin),     32'(m_pin));
            chk("status_led",     32'(status_led),     32'(m_led));
            chk("result_out",     32'(result_out),     32'(m_out));
            chk("result_pending", 32'(result_pending), 32'(m_pend));
            chk("result_overrun", 32'(result_overrun), 32'(m_ovr));
            chk("btn_level",      32'(btn_level),      32'(m_level));
            chk("btn_pulse",      32'(btn_pulse),      32'(m_pulse));
            chk("heartbeat",      32'(heartbeat),      32'(m_hb));
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [31:0] all_outputs();
        return 32'({status_pin, status_led, result_out, result_pending,
                    result_overrun, btn_level, btn_pulse, heartbeat});
    endfunction

    task automatic step(input logic [NS-1:0] st, input logic v, input logic cl,
                        input logic [RW-1:0] r, input logic raw);
        @(negedge clk);
        status_in = st; result_valid = v; result_clear = cl; result_in = r; btn_raw = raw;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        status_in = '0; result_valid = 1'b0; result_clear = 1'b0; result_in = '0; btn_raw = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_zero", all_outputs(), 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        logic [14:0] hbv;
        int cnt, first, last, other, pin_cnt, pcnt;

        do_reset();

        // Heartbeat from release: low for edges 1..4, high 5..9, low 10..14, high at 15.
        for (int c = 0; c < 15; c++) begin
            step('0, 1'b0, 1'b0, '0, 1'b0);
            hbv[c] = heartbeat;
        end
        chk("hb_pattern", 32'(hbv), 32'h41F0);

        // Single-cycle pulse on channel 1: LED high 9 cycles starting 1 after pin.
        cnt = 0; first = -1; other = 0; pin_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            step((c == 0) ? 3'b010 : 3'b000, 1'b0, 1'b0, '0, 1'b0);
            if (status_pin[1]) pin_cnt++;
            if (status_led[1]) begin cnt++; if (first < 0) first = c; end
            if (status_led[0] || status_led[2]) other++;
        end
        chk("pulse_pin_cycles", 32'(pin_cnt), 32'd1);
        chk("pulse_led_cycles", 32'(cnt), 32'd9);
        chk("pulse_led_start",  32'(first), 32'd1);
        chk("pulse_led_others", 32'(other), 32'd0);

        // Retrigger during hold on channel 0: continuous until 8 after the second pin pulse.
        cnt = 0; first = -1; last = -1;
        for (int c = 0; c < 21; c++) begin
            step((c == 0 || c == 5) ? 3'b001 : 3'b000, 1'b0, 1'b0, '0, 1'b0);
            if (status_led[0]) begin cnt++; if (first < 0) first = c; last = c; end
        end
        chk("retrig_led_cycles", 32'(cnt), 32'd14);
        chk("retrig_led_first",  32'(first), 32'd1);
        chk("retrig_led_last",   32'(last), 32'd14);

        // Overrun: 7 then 3 without clear.
        step('0, 1'b1, 1'b0, 4'h7, 1'b0);
        step('0, 1'b0, 1'b0, 4'h0, 1'b0);
        step('0, 1'b1, 1'b0, 4'h3, 1'b0);
        chk("ovr_out",     32'(result_out), 32'h3);
        chk("ovr_pending", 32'(result_pending), 32'd1);
        chk("ovr_flag",    32'(result_overrun), 32'd1);
        step('0, 1'b0, 1'b1, 4'h0, 1'b0);
        chk("clr_out",     32'(result_out), 32'h3);
        chk("clr_pending", 32'(result_pending), 32'd0);
        chk("clr_sticky",  32'(result_overrun), 32'd1);

        // Same-cycle valid and clear while pending: valid wins, no overrun.
        do_reset();
        step('0, 1'b1, 1'b0, 4'h5, 1'b0);
        chk("first_valid_no_ovr", 32'(result_overrun), 32'd0);
        step('0, 1'b1, 1'b1, 4'h9, 1'b0);
        chk("both_out",     32'(result_out), 32'h9);
        chk("both_pending", 32'(result_pending), 32'd1);
        chk("both_no_ovr",  32'(result_overrun), 32'd0);

        // Button glitch of 3 cycles is rejected.
        for (int c = 0; c < 4; c++) step('0, 1'b0, 1'b0, '0, 1'b0);
        cnt = 0; pcnt = 0;
        for (int c = 0; c < 12; c++) begin
            step('0, 1'b0, 1'b0, '0, (c < 3));
            if (btn_level) cnt++;
            if (btn_pulse) pcnt++;
        end
        chk("glitch_level", 32'(cnt), 32'd0);
        chk("glitch_pulse", 32'(pcnt), 32'd0);

        // Held press: level rises DEB edges after sync first differs, one pulse.
        first = -1; pcnt = 0; last = -1;
        for (int c = 0; c < 12; c++) begin
            step('0, 1'b0, 1'b0, '0, 1'b1);
            if (btn_level && first < 0) first = c;
            if (btn_pulse) begin pcnt++; last = c; end
        end
        chk("press_rise_cycle", 32'(first), 32'd5);
        chk("press_pulse_count", 32'(pcnt), 32'd1);
        chk("press_pulse_cycle", 32'(last), 32'd5);

        // Release: level falls with the same delay, no pulse.
        first = -1; pcnt = 0;
        for (int c = 0; c < 12; c++) begin
            step('0, 1'b0, 1'b0, '0, 1'b0);
            if (!btn_level && first < 0) first = c;
            if (btn_pulse) pcnt++;
        end
        chk("release_fall_cycle", 32'(first), 32'd5);
        chk("release_no_pulse", 32'(pcnt), 32'd0);

        // Asynchronous reset mid heartbeat-high with live status and pending result.
        do_reset();
        for (int c = 0; c < 16; c++) begin
            step(3'b101, (c == 0), 1'b0, 4'hA, 1'b0);
        end
        chk("pre_rst_hb",      32'(heartbeat), 32'd1);
        chk("pre_rst_pending", 32'(result_pending), 32'd1);
        chk("pre_rst_led",     32'(status_led), 32'b101);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_zero", all_outputs(), 32'h0);
        do_reset();
        for (int c = 0; c < 6; c++) step('0, 1'b0, 1'b0, '0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
